// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine that owns HI/LO.
// Shift-add multiply and restoring divide run on magnitudes; FIX applies the signs and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d, res;
  logic [WIDTH-1:0]   mc_q, mc_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b, q_f, r_f;
  logic [WIDTH:0]     sum, up, diff;
  logic               div_q, div_d, rsgn_q, rsgn_d, msgn_q, msgn_d, dz_q, dz_d;
  logic               busy_q, done_q, dzo_q, done_d, a_neg, b_neg, ge;
  assign a_neg = !op[0] && a[WIDTH-1];
  assign b_neg = !op[0] && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
  // p_q holds {accumulator/remainder, multiplier/quotient}; mc_q is multiplicand or divisor
  assign sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mc_q} : '0);
  assign up    = p_q[2*WIDTH-1:WIDTH-1];
  assign diff  = up - {1'b0, mc_q};
  assign ge    = !diff[WIDTH];
  assign q_f   = rsgn_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign r_f   = msgn_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  assign res   = !div_q ? (rsgn_q ? -p_q : p_q) : dz_q ? {a_q, {WIDTH{1'b1}}} : {r_f, q_f};
  assign done_d = state_q == FIX && !cancel;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mc_d    = mc_q;
    a_d     = a_q;
    div_d   = div_q;
    rsgn_d  = rsgn_q;
    msgn_d  = msgn_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q != IDLE && cancel) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start && !cancel) begin
      if (!op[2]) begin
        state_d = RUN;
        cnt_d   = CW'(WIDTH - 1);
        div_d   = op[1];
        a_d     = a;
        rsgn_d  = a_neg ^ b_neg;
        msgn_d  = a_neg;
        dz_d    = op[1] && b == '0;
        mc_d    = op[1] ? mag_b : mag_a;
        p_d     = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
      end else if (!op[1]) begin
        hi_d = op[0] ? hi_q : a;
        lo_d = op[0] ? a : lo_q;
      end
    end else if (state_q == RUN) begin
      p_d     = div_q ? {ge ? diff[WIDTH-1:0] : up[WIDTH-1:0], p_q[WIDTH-2:0], ge}
                      : {sum, p_q[WIDTH-1:1]};
      cnt_d   = cnt_q - CW'(cnt_q != '0);
      state_d = cnt_q == '0 ? FIX : RUN;
    end else if (state_q == FIX) begin
      {hi_d, lo_d} = res;
      state_d      = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mc_q    <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      msgn_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mc_q    <= mc_d;
      a_q     <= a_d;
      div_q   <= div_d;
      rsgn_q  <= rsgn_d;
      msgn_q  <= msgn_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
      dzo_q   <= done_d && div_q && dz_q;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces the separate combinational DIV/DIVU/MULT/MULTU blocks and the latch-style HI/LO logic with one registered, multi-cycle engine. The engine exposes a start/busy/done handshake and the core stalls on `busy`. It supports signed and unsigned operation, MTHI/MTLO writes, abort on exception, and a defined divide-by-zero result at any even `WIDTH`.

## Interface

Parameters:

- `WIDTH`, default 32: operand width and width of each of HI and LO. Must be even and at least 4.

Ports:

- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request. Sampled only when `busy`=0.
- `op`, input, 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MTHI, 101 MTLO.
  - 11x reserved; `start` with 11x is a no-op.
- `cancel`, input, 1: abort the in-flight operation (exception or ERET path).
- `a`, input, `WIDTH`: rs operand (dividend or multiplicand, or MT source).
- `b`, input, `WIDTH`: rt operand (divisor or multiplier).
- `busy`, output, 1: an arithmetic operation is in flight.
- `done`, output, 1: one-cycle pulse; HI/LO hold the new result.
- `div_zero`, output, 1: valid only while `done`=1; 1 marks a DIV/DIVU whose divisor was 0.
- `hi`, output, `WIDTH`: HI register.
- `lo`, output, `WIDTH`: LO register.

## Operation

- State machine has three states:
  - IDLE.
  - RUN: iterate, counter runs `WIDTH`-1 down to 0.
  - FIX: sign correction and HI/LO write.
- Transitions:
  - IDLE -> RUN on `start` with op 0xx.
  - RUN -> FIX when the counter reaches 0.
  - FIX -> IDLE unconditionally.
  - `cancel` takes RUN or FIX -> IDLE.
- Operand capture at the accepting edge:
  - `a`, `b` and `op` are latched; later changes have no effect.
  - Signed ops latch magnitudes plus a result-sign flag and a remainder-sign flag.
- Multiply: radix-2 shift-add over `WIDTH` iterations, producing a 2·`WIDTH` product.
  - FIX negates the product if the signs differ.
  - FIX writes {HI,LO} = product.
- Divide: radix-2 restoring division over `WIDTH` iterations on magnitudes.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero, detected at capture:
  - The iteration still runs the full length.
  - FIX writes LO = all ones and HI = original `a`.
  - `div_zero`=1 with `done`.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0, with no flag.
- MTHI/MTLO:
  - When `start`=1 and `busy`=0, `a` is written to HI or LO at that edge.
  - No busy, no `done`.
- Requests that are ignored:
  - `start` while `busy`=1 (all ops, including MTHI/MTLO). The core guarantees this does not happen; the unit must not corrupt state if it does.
- `cancel`:
  - With `busy`=1: HI/LO keep their pre-operation values and `done` is never pulsed for that op.
  - With `busy`=0: no effect.
  - Asserted together with `start` in IDLE: `cancel` wins and the request is dropped (MT writes included).
- Reset (asynchronous, any state, including mid-operation) forces:
  - state IDLE
  - `hi`=0, `lo`=0
  - `busy`=0, `done`=0, `div_zero`=0
  - all internal counters and accumulators 0.

## Timing

- Let the accepting edge be E0.
- `busy`:
  - Registered; high from just after E0 until just after E(`WIDTH`+1).
  - High for `WIDTH`+1 cycles in total (33 for `WIDTH`=32).
- HI/LO are written at E(`WIDTH`+1).
- `done`:
  - Registered; high for exactly one cycle after E(`WIDTH`+1).
  - `busy` is 0 in that same cycle.
  - `div_zero` is valid only in that cycle and 0 otherwise.
- Back-to-back issue: a new `start` may be accepted at the edge that ends the `done` cycle, giving throughput of one op per `WIDTH`+2 cycles.
- MTHI/MTLO: `hi`/`lo` change at the accepting edge, so latency is 1.
- `cancel` sampled at edge Ec gives `busy`=0 after Ec.
- All outputs come straight from registers; there is no combinational path from input to output.

## Test plan

- MULT, a=0xFFFFFFFD (-3), b=7:
  - `busy` high for 33 cycles.
  - Then `done` pulses once with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV and DIVU:
  - DIV -7/2 (0xFFFFFFF9, 2): LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2: LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, `div_zero`=0.
- Divide by zero:
  - DIVU a=0x12345678, b=0: LO=0xFFFFFFFF, HI=0x12345678, `div_zero`=1 for one cycle.
  - Same with DIV gives the same result.
- Cancel and ignored start:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO (visible one edge later, no `done`).
  - Start MULT, assert `cancel` on the 10th busy cycle: `busy` drops next cycle, no `done`, HI/LO stay 0x11/0x22.
  - A `start` issued mid-busy changes nothing.
- Reset and narrow width:
  - Drop `rst` asynchronously mid-DIV: all outputs go to 0 immediately.
  - `WIDTH`=8 instance, MULT 0x80 × 0x80: HI=0x40, LO=0x00 after 9 busy cycles.
